// File: rtl/row_driver_seq.sv
// ============================================================================
// Module      : row_driver_seq
// Description : Word-line sequencer issuing WRITE / MAC bursts and CAM searches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_driver_seq #(
  parameter int ROWS = 16,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            preb,
  input  logic            cs,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            read_bar,
  input  logic [AW-1:0]   addr,
  input  logic [AW-1:0]   burst_len,
  input  logic [ROWS-1:0] data,
  output logic [ROWS-1:0] WL,
  output logic [ROWS-1:0] WLB,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   row_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] c_mode_write = 2'b00;
  localparam logic [1:0] c_mode_mac   = 2'b01;
  localparam logic [1:0] c_mode_cam   = 2'b10;
  localparam logic [1:0] c_mode_rsvd  = 2'b11;

  state_t          r_state;
  logic [1:0]      r_mode;
  logic            r_read_bar;
  logic [ROWS-1:0] r_data;
  logic [AW-1:0]   r_row;
  logic [AW-1:0]   r_remaining;
  logic [ROWS-1:0] r_wl;
  logic [ROWS-1:0] r_wlb;

  logic            w_accept;
  logic [AW-1:0]   w_next_row;
  logic [ROWS-1:0] w_first_wl;
  logic [ROWS-1:0] w_first_wlb;
  logic [ROWS-1:0] w_next_wl;
  logic [ROWS-1:0] w_next_wlb;

  // Word-line pair for one row; CAM ignores the row and drives the key.
  function automatic logic [2*ROWS-1:0] f_pattern(
    input logic [1:0]      m,
    input logic            rb,
    input logic [ROWS-1:0] d,
    input logic [AW-1:0]   r
  );
    logic [ROWS-1:0] oh;
    logic [ROWS-1:0] wl;
    logic [ROWS-1:0] wlb;
    oh  = {{(ROWS-1){1'b0}}, 1'b1} << r;
    wl  = '0;
    wlb = '0;
    case (m)
      c_mode_write: begin
        wl  = oh;
        wlb = oh;
      end
      c_mode_mac: begin
        if (rb) wlb = oh;
        else    wl  = oh;
      end
      c_mode_cam: begin
        wl  = d;
        wlb = ~d;
      end
      default: begin
        wl  = '0;
        wlb = '0;
      end
    endcase
    return {wl, wlb};
  endfunction

  assign w_accept   = start && (mode != c_mode_rsvd);
  assign w_next_row = r_row + 1'b1;
  assign {w_first_wl, w_first_wlb} = f_pattern(mode, read_bar, data, addr);
  assign {w_next_wl, w_next_wlb}   = f_pattern(r_mode, r_read_bar, r_data, w_next_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= c_mode_write;
      r_read_bar  <= 1'b0;
      r_data      <= '0;
      r_row       <= '0;
      r_remaining <= '0;
      r_wl        <= '0;
      r_wlb       <= '0;
    end else if (!cs) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_remaining <= '0;
      r_wl        <= '0;
      r_wlb       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ACTIVE;
            r_mode      <= mode;
            r_read_bar  <= read_bar;
            r_data      <= data;
            r_row       <= addr;
            r_remaining <= (mode == c_mode_cam) ? '0 : burst_len;
            r_wl        <= w_first_wl;
            r_wlb       <= w_first_wlb;
          end
        end
        S_ACTIVE: begin
          // Precharge cycles hold everything; only preb-high edges consume a row.
          if (preb) begin
            if (r_remaining != '0) begin
              r_row       <= w_next_row;
              r_remaining <= r_remaining - 1'b1;
              r_wl        <= w_next_wl;
              r_wlb       <= w_next_wlb;
            end else begin
              r_state <= S_DONE;
              r_row   <= '0;
              r_wl    <= '0;
              r_wlb   <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_wl    <= '0;
          r_wlb   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_wl    <= '0;
          r_wlb   <= '0;
        end
      endcase
    end
  end

  assign WL      = preb ? r_wl  : '0;
  assign WLB     = preb ? r_wlb : '0;
  assign busy    = (r_state == S_ACTIVE);
  assign done    = (r_state == S_DONE);
  assign row_idx = busy ? r_row : '0;

endmodule

`default_nettype wire

// File: tb/tb_row_driver_seq.sv
// ============================================================================
// Module      : tb_row_driver_seq
// Description : Directed vector bench for row_driver_seq (ROWS=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_row_driver_seq;

  localparam int ROWS = 16;
  localparam int AW   = 4;
  localparam int NVEC = 25;

  logic            clk;
  logic            rst_n;
  logic            preb;
  logic            cs;
  logic            start;
  logic [1:0]      mode;
  logic            read_bar;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   burst_len;
  logic [ROWS-1:0] data;
  logic [ROWS-1:0] WL;
  logic [ROWS-1:0] WLB;
  logic            busy;
  logic            done;
  logic [AW-1:0]   row_idx;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic            preb;
    logic            cs;
    logic            start;
    logic [1:0]      mode;
    logic            read_bar;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   burst_len;
    logic [ROWS-1:0] data;
    logic [ROWS-1:0] exp_wl;
    logic [ROWS-1:0] exp_wlb;
    logic            exp_busy;
    logic            exp_done;
    logic [AW-1:0]   exp_row;
  } vec_t;

  vec_t vecs [NVEC];

  row_driver_seq #(.ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .preb      (preb),
    .cs        (cs),
    .start     (start),
    .mode      (mode),
    .read_bar  (read_bar),
    .addr      (addr),
    .burst_len (burst_len),
    .data      (data),
    .WL        (WL),
    .WLB       (WLB),
    .busy      (busy),
    .done      (done),
    .row_idx   (row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [ROWS-1:0] ewl, input logic [ROWS-1:0] ewlb,
                           input logic eb, input logic ed, input logic [AW-1:0] er);
    check({tag, ".WL"},      32'(WL),      32'(ewl));
    check({tag, ".WLB"},     32'(WLB),     32'(ewlb));
    check({tag, ".busy"},    32'(busy),    32'(eb));
    check({tag, ".done"},    32'(done),    32'(ed));
    check({tag, ".row_idx"}, 32'(row_idx), 32'(er));
  endtask

  task automatic drive(input logic p, input logic c, input logic s, input logic [1:0] m,
                       input logic rb, input logic [AW-1:0] a, input logic [AW-1:0] bl,
                       input logic [ROWS-1:0] d);
    preb = p; cs = c; start = s; mode = m; read_bar = rb; addr = a; burst_len = bl; data = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            preb cs st mode  rb addr   len    data      WL        WLB       bsy dn row
    // WRITE addr=3 len=0
    vecs[0]  = '{1'b1,1'b1,1'b1,2'b00,1'b0,4'd3, 4'd0,16'h0000,16'h0008,16'h0008,1'b1,1'b0,4'd3};
    vecs[1]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'd0};
    vecs[2]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    // MAC read_bar=0 addr=14 len=3, wraps 15->0; start while busy ignored
    vecs[3]  = '{1'b1,1'b1,1'b1,2'b01,1'b0,4'd14,4'd3,16'h0000,16'h4000,16'h0000,1'b1,1'b0,4'd14};
    vecs[4]  = '{1'b1,1'b1,1'b1,2'b00,1'b0,4'd5, 4'd0,16'h0000,16'h8000,16'h0000,1'b1,1'b0,4'd15};
    vecs[5]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0001,16'h0000,1'b1,1'b0,4'd0};
    vecs[6]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0002,16'h0000,1'b1,1'b0,4'd1};
    vecs[7]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'd0};
    vecs[8]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    // CAM key 0xA5C3, burst_len=7 has no effect; start in DONE ignored
    vecs[9]  = '{1'b1,1'b1,1'b1,2'b10,1'b0,4'd2, 4'd7,16'hA5C3,16'hA5C3,16'h5A3C,1'b1,1'b0,4'd2};
    vecs[10] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'd0};
    vecs[11] = '{1'b1,1'b1,1'b1,2'b00,1'b0,4'd6, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    // reserved mode and cs=0 starts ignored
    vecs[12] = '{1'b1,1'b1,1'b1,2'b11,1'b0,4'd6, 4'd2,16'hFFFF,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    vecs[13] = '{1'b1,1'b0,1'b1,2'b00,1'b0,4'd6, 4'd2,16'hFFFF,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    // MAC read_bar=1 addr=0 len=2 with two precharge cycles after row 1
    vecs[14] = '{1'b1,1'b1,1'b1,2'b01,1'b1,4'd0, 4'd2,16'h0000,16'h0000,16'h0001,1'b1,1'b0,4'd0};
    vecs[15] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0002,1'b1,1'b0,4'd1};
    vecs[16] = '{1'b0,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b1,1'b0,4'd1};
    vecs[17] = '{1'b0,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b1,1'b0,4'd1};
    vecs[18] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0004,1'b1,1'b0,4'd2};
    vecs[19] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,4'd0};
    vecs[20] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    // 4-row MAC aborted by cs=0 during row 2
    vecs[21] = '{1'b1,1'b1,1'b1,2'b01,1'b0,4'd4, 4'd3,16'h0000,16'h0010,16'h0000,1'b1,1'b0,4'd4};
    vecs[22] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0020,16'h0000,1'b1,1'b0,4'd5};
    vecs[23] = '{1'b1,1'b0,1'b1,2'b01,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};
    vecs[24] = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0, 4'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,4'd0};

    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, '0, '0, '0);
    #2;
    check_all("reset", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].preb, vecs[i].cs, vecs[i].start, vecs[i].mode, vecs[i].read_bar,
            vecs[i].addr, vecs[i].burst_len, vecs[i].data);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_wl, vecs[i].exp_wlb,
                vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_row);
    end

    // Asynchronous reset in the middle of a MAC burst
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 4'd7, '0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_all("pre_rst", 16'h0002, 16'h0, 1'b1, 1'b0, 4'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);

    // First start after reset release is accepted at the next edge
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd9, 4'd0, '0);
    @(posedge clk);
    #1;
    check_all("post_rst_wr", 16'h0200, 16'h0200, 1'b1, 1'b0, 4'd9);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst_done", 16'h0, 16'h0, 1'b0, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/row_driver_seq.md
ROW_DRIVER_SEQ -- requirements
Module: row_driver_seq

Interface
REQ-001 Parameter ROWS, default 16, number of word lines; SHALL be a power of two, 4 to 256.
REQ-002 Parameter AW, default $clog2(ROWS), row address width; SHALL be derived from ROWS and never overridden.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 preb  input  1  precharge-bar; 0 = precharge phase, word lines forced off.
REQ-006 cs  input  1  chip select; 0 aborts any operation and idles the block.
REQ-007 start  input  1  operation request, sampled only in IDLE.
REQ-008 mode  input  2  00 WRITE, 01 MAC, 10 CAM, 11 reserved.
REQ-009 read_bar  input  1  MAC polarity; 1 drives WLB side, 0 drives WL side.
REQ-010 addr  input  AW  first row of the operation.
REQ-011 burst_len  input  AW  rows minus one for WRITE/MAC (0 = one row).
REQ-012 data  input  ROWS  CAM search key.
REQ-013 WL  output  ROWS  true-side word lines.
REQ-014 WLB  output  ROWS  complement-side word lines.
REQ-015 busy  output  1  high while state is ACTIVE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 row_idx  output  AW  row currently issued; 0 when not ACTIVE.

Function
REQ-018 FSM states IDLE, ACTIVE, DONE; WL_r, WLB_r, row counter and remaining-row counter are registered.
REQ-019 IDLE: start=1, cs=1, mode!=11 at an edge -> capture mode, read_bar, data, row=addr, remaining=burst_len (0 for CAM), load first row pattern into WL_r/WLB_r, enter ACTIVE.
REQ-020 start with mode=11, with cs=0, or outside IDLE SHALL be ignored with no state change.
REQ-021 Row pattern: WRITE WL_r=WLB_r=onehot(row); MAC read_bar=0 WL_r=onehot(row), WLB_r=0; MAC read_bar=1 WL_r=0, WLB_r=onehot(row); CAM WL_r=data, WLB_r=~data (captured values).
REQ-022 A row is issued on each ACTIVE cycle with preb=1; at that edge, remaining>0 -> row=(row+1) mod ROWS, remaining-1, load next pattern; remaining=0 -> WL_r=WLB_r=0, enter DONE.
REQ-023 ACTIVE with preb=0 SHALL hold row, remaining, WL_r, WLB_r unchanged (precharge cycles consume no row).
REQ-024 Row increment SHALL wrap ROWS-1 -> 0 without error.
REQ-025 Total issued rows = burst_len+1 for WRITE/MAC, exactly 1 for CAM; first row visible the cycle after start is accepted.
REQ-026 DONE lasts exactly one cycle with done=1, WL_r=WLB_r=0, then IDLE; start in DONE ignored.
REQ-027 WL = preb ? WL_r : 0; WLB = preb ? WLB_r : 0, combinational gating in every state.
REQ-028 cs=0 at any edge -> WL_r=WLB_r=0, counters 0, state IDLE, no done pulse, regardless of start.
REQ-029 IDLE SHALL hold WL_r=WLB_r=0; WL and WLB never both nonzero on the same row except in WRITE and CAM.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force state IDLE, WL_r=WLB_r=0, counters 0, busy=0, done=0, row_idx=0.
REQ-031 rst_n=0 mid-operation aborts it with no done pulse; first start is accepted at the first edge after rst_n rises.

Verification (ROWS=16, preb=1, cs=1 unless stated)
REQ-032 Reset asserted mid-MAC burst -> WL=WLB=0x0000, busy=0, done=0 before the next clk edge.
REQ-033 WRITE addr=3 len=0 -> WL=WLB=0x0008 one cycle, then done=1 one cycle, then IDLE.
REQ-034 MAC read_bar=0 addr=14 len=3 -> WL 0x4000,0x8000,0x0001,0x0002 on consecutive cycles, WLB=0, row_idx 14,15,0,1, then done.
REQ-035 CAM data=0xA5C3 -> WL=0xA5C3, WLB=0x5A3C for one cycle, then done; burst_len=7 has no effect.
REQ-036 MAC read_bar=1 addr=0 len=2, preb=0 for two cycles after row 1 issued -> WLB=0 during precharge, row_idx held at 1, then rows 1,2 resume; exactly 3 preb-high rows issued.
REQ-037 cs=0 during row 2 of a 4-row MAC -> WL=WLB=0 after that edge, IDLE, done never pulses; start asserted while busy is ignored.
